inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the instruction memory.
- Owns the program counter and drives the word address to inst_mem each cycle; inst_mem returns the instruction combinationally in the same cycle.
- Captures each {pc, instruction} pair into a small in-order fetch buffer.
- Presents buffered instructions to decode over a valid/ready handshake, and takes branch/jump redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_WORDS, 16, number of valid instruction words; a word index at or above this is out of range.
- FB_DEPTH, 2, fetch buffer entries, power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_pc  out  32  byte address to instruction memory; equals the internal PC.
- imem_instr  in  32  instruction word, valid combinationally for the current imem_pc.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_target.
- redirect_target  in  32  new byte PC.
- id_valid  out  1  head of the fetch buffer is valid.
- id_ready  in  1  decode accepts the head.
- id_instr  out  32  instruction at the head.
- id_pc  out  32  PC of the head instruction.
- id_pc_plus4  out  32  id_pc + 4, mod 2^32.
- halted  out  1  fetch stopped because the PC is out of range.
- fault  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - PC = RESET_PC, state FETCH, buffer empty.
  - id_valid = 0, id_instr/id_pc = 0, id_pc_plus4 = 4, halted = 0, fault = 0.
- States: FETCH, HALT.
- FETCH, no redirect:
  - Enqueue is allowed if the buffer is not full, or if it is full and a pop occurs this cycle.
  - If allowed: push {imem_pc, imem_instr}, then PC <= PC + 4 (32-bit wrap).
  - Otherwise PC holds and imem_pc stays stable.
- Out-of-range check: if PC[31:2] >= IMEM_WORDS at the enqueue decision, nothing is pushed, state goes to HALT, and halted = 1 from the next cycle.
- HALT:
  - No enqueue, PC frozen.
  - The buffer keeps draining to decode.
  - Only a redirect or reset leaves HALT.
- Latency: an instruction pushed in cycle N shows id_valid = 1 in cycle N+1. Sustained throughput is 1 instruction/cycle with id_ready held high.
- Handshake:
  - A pop occurs when id_valid & id_ready.
  - While id_valid = 1 and no pop occurs, id_instr, id_pc and id_pc_plus4 hold stable.
  - id_valid never drops without a pop, except on a redirect.
- Redirect (highest priority, any state):
  - A pop in the same cycle still completes (decode consumed the head).
  - All other entries are flushed. No push that cycle; the instruction at the old PC is discarded.
  - PC <= redirect_target, state <= FETCH, halted <= 0.
  - id_valid = 0 in the next cycle. The target instruction appears on id outputs in the cycle after that.
- Buffer: circular, read/write pointers of clog2(FB_DEPTH)+1 bits. Full and empty are decided by the MSB compare.
- Simultaneous push and pop when full: legal, and occupancy is unchanged.
- Simultaneous push and pop when empty: the pushed entry becomes the head next cycle. There is no combinational bypass.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect_target with bits [1:0] != 0 sets fault = 1 (sticky until reset).
  - State goes to HALT and halted = 1. The PC is loaded but not fetched; the flush still occurs.
- Undefined:
  - redirect_target[1:0] is forced to 2'b00.
  - fault is tied 0.

Decomposition:
- Shared package: PC width (32), instruction width (32), byte-to-word shift (2), the FETCH/HALT state encoding, and the fetch-buffer entry struct {pc, instr}.
- One natural sub-module: fetch_fifo, a parameterized synchronous FIFO (depth and width parameters, push/pop/full/empty, sync flush input), instantiated once.

Test Plan:
- Reset then id_ready = 1, imem model returns word = 0x1000_0000 + index:
  - cycle 1: id_valid = 1, id_pc = 0, id_instr = 0x1000_0000, id_pc_plus4 = 4.
  - cycle 2: id_pc = 4, id_instr = 0x1000_0001.
- Backpressure: id_ready = 0 for 5 cycles.
  - Buffer fills to FB_DEPTH, imem_pc frozen at 8, id outputs stable.
  - Release: pcs 0, 4, 8, ... delivered in order, with no loss or duplicate.
- Redirect to 0x20 while the buffer holds pcs 4 and 8, pop in the same cycle:
  - pc 4 is consumed, pc 8 is dropped, next cycle id_valid = 0.
  - The following cycle shows id_pc = 0x20, id_instr = 0x1000_0008.
- Sequential fetch to pc = 0x40 (IMEM_WORDS = 16):
  - halted = 1, the last delivered id_pc is 0x3C, id_valid = 0 after drain.
  - Redirect to 0 clears halted and fetch resumes.
- Async reset asserted mid-stream with the buffer full: all outputs return to reset values immediately, without waiting for clk.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x22: fault = 1, halted = 1, no further id_valid.
  - Without the macro: fetch resumes at 0x20 and fault stays 0.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, FSM encoding and fetch-buffer entry type for the instruction fetch unit.
package inst_fetch_unit_pkg;

  localparam int PC_W       = 32;
  localparam int INSTR_W    = 32;
  localparam int WORD_SHIFT = 2;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fb_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirect) and decode.
interface inst_fetch_unit_if;
  import inst_fetch_unit_pkg::*;

  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    id_pc_plus4;
  logic               halted;
  logic               fault;

  modport master (
    output imem_pc,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_target,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output halted,
    output fault
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    output redirect_valid,
    output redirect_target,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  halted,
    input  fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with extra-MSB pointers for full/empty and a synchronous flush.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Flush wins over push/pop so a redirect leaves the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, buffers {pc, instr} pairs and hands them to decode.
// Optional misaligned-redirect trap is enabled with the FETCH_ALIGN_CHECK_EN macro.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16,
  parameter int          FB_DEPTH   = 2
) (
  input logic                clk,
  input logic                rst_n,
  inst_fetch_unit_if.master  bus
);

  localparam logic [PC_W-1:0] IMEM_LIMIT = PC_W'(IMEM_WORDS);

  fetch_state_e    state, state_nx;
  logic [PC_W-1:0] pc, pc_nx, target;
  fb_entry_t       head, wentry;
  logic            push, pop, flush, full, empty, can_enq, in_range, misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign target     = bus.redirect_target;
  assign misaligned = |bus.redirect_target[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               fault_q <= 1'b0;
    else if (bus.redirect_valid && misaligned) fault_q <= 1'b1;
  end

  assign bus.fault = fault_q;
`else
  assign target     = bus.redirect_target & ~32'h3;
  assign misaligned = 1'b0;
  assign bus.fault  = 1'b0;
`endif

  assign pop      = !empty && bus.id_ready;
  assign can_enq  = !full || pop;
  assign in_range = (pc >> WORD_SHIFT) < IMEM_LIMIT;
  assign wentry   = '{pc: pc, instr: bus.imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

  // Redirect overrides everything; a misaligned target is loaded but parked in HALT.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    push     = 1'b0;
    flush    = 1'b0;
    if (bus.redirect_valid) begin
      flush    = 1'b1;
      pc_nx    = target;
      state_nx = misaligned ? HALT : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (can_enq) begin
            if (!in_range) begin
              state_nx = HALT;
            end else begin
              push  = 1'b1;
              pc_nx = pc + 32'd4;
            end
          end
        end
        HALT:    ;
        default: state_nx = FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FB_DEPTH),
    .WIDTH ($bits(fb_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs read zero while the buffer is empty so reset values are well defined.
  assign bus.imem_pc     = pc;
  assign bus.id_valid    = !empty;
  assign bus.id_pc       = empty ? '0 : head.pc;
  assign bus.id_instr    = empty ? '0 : head.instr;
  assign bus.id_pc_plus4 = bus.id_pc + 32'd4;
  assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed scoreboard bench for inst_fetch_unit (honours FETCH_ALIGN_CHECK_EN if defined).
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (16),
    .FB_DEPTH   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word at index i holds 0x1000_0000 + i.
  assign bus.imem_instr = 32'h1000_0000 + {2'b00, bus.imem_pc[31:2]};

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_pc = 32'hFFFF_FFFF;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [31:0] rt);
    bus.id_ready        = ready;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
  endtask

  // Compares the head against the scoreboard whenever decode is about to consume it.
  task automatic checkOutput();
    logic [31:0] exp_pc;
    if (bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("[TB] FAIL unexpected_pop observed=%h expected=none", bus.id_pc);
      end
      if (exp_q.size() != 0) begin
        exp_pc = exp_q.pop_front();
        checkValue("pop_pc", bus.id_pc, exp_pc);
        checkValue("pop_instr", bus.id_instr, 32'h1000_0000 + (exp_pc >> 2));
        checkValue("pop_pc_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
        last_pc = bus.id_pc;
      end
    end
  endtask

  task automatic stepCycle();
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #3;
    $display("[TB] reset values");
    checkValue("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkValue("rst_id_pc", bus.id_pc, 32'h0);
    checkValue("rst_id_instr", bus.id_instr, 32'h0);
    checkValue("rst_id_pc_plus4", bus.id_pc_plus4, 32'h4);
    checkValue("rst_halted", {31'b0, bus.halted}, 32'd0);
    checkValue("rst_fault", {31'b0, bus.fault}, 32'd0);
    checkValue("rst_imem_pc", bus.imem_pc, 32'h0);

    // Streaming from reset with decode always ready.
    @(posedge clk); #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    stepCycle();
    checkValue("c1_id_valid", {31'b0, bus.id_valid}, 32'd1);
    checkValue("c1_id_pc", bus.id_pc, 32'h0);
    checkValue("c1_id_instr", bus.id_instr, 32'h1000_0000);
    checkValue("c1_id_pc_plus4", bus.id_pc_plus4, 32'h4);
    stepCycle();
    checkValue("c2_id_pc", bus.id_pc, 32'h4);
    checkValue("c2_id_instr", bus.id_instr, 32'h1000_0001);

    // Fill the buffer, then assert reset between clock edges.
    applyStimulus(1'b0, 1'b0, 32'h0);
    stepCycle();
    stepCycle();
    checkValue("full_id_pc", bus.id_pc, 32'h4);
    checkValue("full_imem_pc", bus.imem_pc, 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("arst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkValue("arst_id_pc", bus.id_pc, 32'h0);
    checkValue("arst_id_instr", bus.id_instr, 32'h0);
    checkValue("arst_id_pc_plus4", bus.id_pc_plus4, 32'h4);
    checkValue("arst_imem_pc", bus.imem_pc, 32'h0);
    checkValue("arst_halted", {31'b0, bus.halted}, 32'd0);
    exp_q.delete();

    // Backpressure from reset: buffer fills with pcs 0 and 4, PC parks at 8.
    @(posedge clk); #2;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int k = 1; k <= 5; k++) begin
      stepCycle();
      checkValue("bp_imem_pc", bus.imem_pc, (k == 1) ? 32'h4 : 32'h8);
      checkValue("bp_id_pc", bus.id_pc, 32'h0);
      checkValue("bp_id_instr", bus.id_instr, 32'h1000_0000);
      checkValue("bp_id_valid", {31'b0, bus.id_valid}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    stepCycle();
    checkValue("rel_id_pc", bus.id_pc, 32'h4);

    // Redirect while pcs 4 and 8 are buffered; pc 4 is popped in the same cycle.
    applyStimulus(1'b1, 1'b1, 32'h20);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkValue("redir_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkValue("redir_imem_pc", bus.imem_pc, 32'h20);
    for (int a = 32'h20; a <= 32'h3C; a += 4) exp_q.push_back(32'(a));
    stepCycle();
    checkValue("redir_tgt_pc", bus.id_pc, 32'h20);
    checkValue("redir_tgt_instr", bus.id_instr, 32'h1000_0008);

    // Run off the end of instruction memory.
    for (int n = 0; n < 40; n++) begin
      stepCycle();
      if (bus.halted === 1'b1) break;
    end
    checkValue("halt_flag", {31'b0, bus.halted}, 32'd1);
    checkValue("halt_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkValue("halt_imem_pc", bus.imem_pc, 32'h40);
    checkValue("halt_last_pc", last_pc, 32'h3C);
    checkValue("halt_queue_left", 32'(exp_q.size()), 32'd0);
    stepCycle();
    stepCycle();
    checkValue("halt_sticky", {31'b0, bus.halted}, 32'd1);
    checkValue("halt_imem_pc_frozen", bus.imem_pc, 32'h40);

    // Redirect out of HALT.
    applyStimulus(1'b1, 1'b1, 32'h0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkValue("resume_halted", {31'b0, bus.halted}, 32'd0);
    checkValue("resume_id_valid", {31'b0, bus.id_valid}, 32'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    stepCycle();
    checkValue("resume_id_pc", bus.id_pc, 32'h0);
    stepCycle();
    checkValue("resume_id_pc2", bus.id_pc, 32'h4);

    // Misaligned redirect target.
    applyStimulus(1'b1, 1'b1, 32'h22);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkValue("align_fault", {31'b0, bus.fault}, 32'd1);
    checkValue("align_halted", {31'b0, bus.halted}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      checkValue("align_id_valid", {31'b0, bus.id_valid}, 32'd0);
      stepCycle();
    end
    checkValue("align_fault_sticky", {31'b0, bus.fault}, 32'd1);
`else
    checkValue("noalign_fault", {31'b0, bus.fault}, 32'd0);
    checkValue("noalign_halted", {31'b0, bus.halted}, 32'd0);
    checkValue("noalign_id_valid", {31'b0, bus.id_valid}, 32'd0);
    checkValue("noalign_imem_pc", bus.imem_pc, 32'h20);
    exp_q.push_back(32'h20);
    stepCycle();
    checkValue("noalign_id_pc", bus.id_pc, 32'h20);
    checkValue("noalign_id_instr", bus.id_instr, 32'h1000_0008);
    checkValue("noalign_fault2", {31'b0, bus.fault}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
